// File: rtl/whackamole_engine.sv
// Whack-a-mole game core: LFSR-driven mole spawning, per-mole lifetimes, a tick-driven
// countdown timer and saturating hit/miss/escape counters for N buttons and LEDs.
module whackamole_engine #(
  parameter int          NUM_MOLES     = 5,
  parameter int          MAX_ACTIVE    = 2,
  parameter int          MOLE_LIFETIME = 3,
  parameter int          GAME_SECONDS  = 30,
  parameter int          SCORE_W       = 8,
  parameter int          MISS_PENALTY  = 0,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         TIME_W        = $clog2(GAME_SECONDS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit_pulse,
  output logic [NUM_MOLES-1:0] mole_led,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [SCORE_W-1:0]   escaped,
  output logic [TIME_W-1:0]    time_left,
  output logic                 game_active,
  output logic                 game_over
);

  localparam int LW   = $clog2(MOLE_LIFETIME + 1);
  localparam int CW   = $clog2(NUM_MOLES + 1);
  localparam int SUMW = ((SCORE_W > CW) ? SCORE_W : CW) + 1;
  localparam logic [SCORE_W-1:0] CNT_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t                        state;
  logic [15:0]                   lfsr;
  logic [NUM_MOLES-1:0][LW-1:0]  life;
  logic [NUM_MOLES-1:0][LW-1:0]  life_next;
  logic [NUM_MOLES-1:0]          hit_mask;
  logic [NUM_MOLES-1:0]          miss_mask;
  logic [NUM_MOLES-1:0]          expire_mask;
  logic [NUM_MOLES-1:0]          spawn_mask;
  logic [CW-1:0]                 hit_cnt;
  logic [CW-1:0]                 miss_cnt;
  logic [CW-1:0]                 expire_cnt;
  logic [CW-1:0]                 lit_cnt;
  logic                          final_tick;
  logic                          live_tick;
  int                            spawn_idx;
  logic [SCORE_W-1:0]            score_next;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [CW-1:0] n);
    logic [SUMW-1:0] s;
    s = SUMW'(a) + SUMW'(n);
    return (s > SUMW'(CNT_MAX)) ? CNT_MAX : SCORE_W'(s);
  endfunction

  function automatic logic [SCORE_W-1:0] floor_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [CW-1:0] n);
    return (SUMW'(a) < SUMW'(n)) ? '0 : SCORE_W'(SUMW'(a) - SUMW'(n));
  endfunction

  always_comb begin
    hit_mask    = hit_pulse & mole_led;
    miss_mask   = hit_pulse & ~mole_led;
    expire_mask = '0;
    spawn_mask  = '0;
    life_next   = life;
    hit_cnt     = '0;
    miss_cnt    = '0;
    expire_cnt  = '0;
    lit_cnt     = '0;
    final_tick  = tick && (time_left == TIME_W'(1));
    live_tick   = tick && !final_tick;
    spawn_idx   = int'(lfsr % 16'(NUM_MOLES));
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit_cnt  = hit_cnt + CW'(hit_mask[i]);
      miss_cnt = miss_cnt + CW'(miss_mask[i]);
      lit_cnt  = lit_cnt + CW'(mole_led[i]);
    end
    // A hit on the expiring tick takes priority: the hit mole is excluded from expiry.
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (live_tick && mole_led[i] && !hit_mask[i]) begin
        if (life[i] == LW'(1)) expire_mask[i] = 1'b1;
        else                   life_next[i]   = life[i] - LW'(1);
      end
    end
    for (int i = 0; i < NUM_MOLES; i++) begin
      expire_cnt = expire_cnt + CW'(expire_mask[i]);
      if (live_tick && i == spawn_idx && !mole_led[i] && lit_cnt < CW'(MAX_ACTIVE)) begin
        spawn_mask[i] = 1'b1;
        life_next[i]  = LW'(MOLE_LIFETIME);
      end
    end
    score_next = sat_add(score, hit_cnt);
    if (MISS_PENALTY != 0) score_next = floor_sub(score_next, miss_cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      life        <= '0;
      mole_led    <= '0;
      score       <= '0;
      misses      <= '0;
      escaped     <= '0;
      time_left   <= '0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state       <= PLAYING;
            life        <= '0;
            mole_led    <= '0;
            score       <= '0;
            misses      <= '0;
            escaped     <= '0;
            time_left   <= TIME_W'(GAME_SECONDS);
            game_active <= 1'b1;
            game_over   <= 1'b0;
          end
        end
        PLAYING: begin
          score  <= score_next;
          misses <= sat_add(misses, miss_cnt);
          if (final_tick) begin
            state       <= OVER;
            time_left   <= '0;
            mole_led    <= '0;
            game_active <= 1'b0;
            game_over   <= 1'b1;
          end else begin
            if (tick) time_left <= time_left - TIME_W'(1);
            mole_led <= (mole_led & ~hit_mask & ~expire_mask) | spawn_mask;
            life     <= life_next;
            escaped  <= sat_add(escaped, expire_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whackamole_engine.sv
// Bench for whackamole_engine: table vectors, directed multi-cycle corners and random
// play, all checked against a lifetime-array reference model of the game rules.
module tb_whackamole_engine;

  localparam int N    = 5;
  localparam int MA   = 2;
  localparam int ML   = 2;
  localparam int GS   = 12;
  localparam int SW   = 3;
  localparam int MP   = 1;
  localparam int TW   = $clog2(GS + 1);
  localparam int SMAX = (1 << SW) - 1;
  localparam int W    = N + 3 * SW + TW + 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          start;
  logic [N-1:0]  hit_pulse;
  logic [N-1:0]  mole_led;
  logic [SW-1:0] score, misses, escaped;
  logic [TW-1:0] time_left;
  logic          game_active, game_over;

  whackamole_engine #(
    .NUM_MOLES(N), .MAX_ACTIVE(MA), .MOLE_LIFETIME(ML), .GAME_SECONDS(GS),
    .SCORE_W(SW), .MISS_PENALTY(MP), .SEED(SEED)
  ) dut (
    .clock(clk), .reset(reset), .tick(tick), .start(start), .hit_pulse(hit_pulse),
    .mole_led(mole_led), .score(score), .misses(misses), .escaped(escaped),
    .time_left(time_left), .game_active(game_active), .game_over(game_over)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: life_m[i] is remaining ticks of mole i, 0 meaning unlit
  int          m_state;  // 0 idle, 1 playing, 2 over
  int          life_m[N];
  int          m_score, m_misses, m_esc, m_time;
  logic [15:0] m_lfsr;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_vec;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  assign dut_vec = {mole_led, score, misses, escaped, time_left, game_active, game_over};

  function automatic logic [N-1:0] m_led();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (life_m[i] > 0);
    return r;
  endfunction

  function automatic logic [N-1:0] m_ones_mask();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (life_m[i] == 1);
    return r;
  endfunction

  function automatic logic [W-1:0] m_pack();
    return {m_led(), SW'(m_score), SW'(m_misses), SW'(m_esc), TW'(m_time),
            m_state == 1, m_state == 2};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_misses = 0; m_esc = 0; m_time = 0;
    m_lfsr = SEED;
    for (int i = 0; i < N; i++) life_m[i] = 0;
  endtask

  task automatic model_step(input bit tk, input bit st, input logic [N-1:0] hp);
    int h, m, lit, idx;
    int nl[N];
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_score = 0; m_misses = 0; m_esc = 0; m_time = GS;
        for (int i = 0; i < N; i++) life_m[i] = 0;
      end
    end else begin
      h = 0; m = 0; lit = 0;
      for (int i = 0; i < N; i++) begin
        nl[i] = life_m[i];
        if (life_m[i] > 0) lit++;
        if (hp[i]) begin
          if (life_m[i] > 0) h++; else m++;
          nl[i] = 0;
        end
      end
      m_score  = imin(m_score + h, SMAX);
      if (MP != 0) m_score = (m_score > m) ? m_score - m : 0;
      m_misses = imin(m_misses + m, SMAX);
      if (tk) begin
        if (m_time == 1) begin
          m_time = 0; m_state = 2;
          for (int i = 0; i < N; i++) nl[i] = 0;
        end else begin
          m_time--;
          for (int i = 0; i < N; i++)
            if (life_m[i] > 0 && !hp[i]) begin
              nl[i] = life_m[i] - 1;
              if (nl[i] == 0) m_esc = imin(m_esc + 1, SMAX);
            end
          idx = int'(m_lfsr) % N;
          if (life_m[idx] == 0 && lit < MA) nl[idx] = ML;
        end
      end
      for (int i = 0; i < N; i++) life_m[i] = nl[i];
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: called just after a falling edge; returns on the next falling edge
  task automatic cycle(input bit tk, input bit st, input logic [N-1:0] hp);
    logic [W-1:0] e;
    tick = tk; start = st; hit_pulse = hp;
    model_step(tk, st, hp);
    exp_q.push_back(m_pack());
    @(posedge clk); #1;
    cyc++;
    e = exp_q.pop_front();
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, dut_vec, e);
    end
    chk($sformatf("cycle %0d led limit ok", cyc), int'($countones(mole_led) <= MA), 1);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; hit_pulse = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mole_led"}, int'(mole_led), 0);
    chk({tag, " score"}, int'(score), 0);
    chk({tag, " misses"}, int'(misses), 0);
    chk({tag, " escaped"}, int'(escaped), 0);
    chk({tag, " time_left"}, int'(time_left), 0);
    chk({tag, " game_active"}, int'(game_active), 0);
    chk({tag, " game_over"}, int'(game_over), 0);
  endtask

  typedef struct {
    bit           tk;
    bit           st;
    logic [N-1:0] hp;
    int           t;
    int           a;
    int           o;
    int           mi;
    int           sc;
  } vec_t;

  function automatic vec_t mk(input bit tk, input bit st, input logic [N-1:0] hp,
                              input int t, input int a, input int o,
                              input int mi, input int sc);
    vec_t v;
    v.tk = tk; v.st = st; v.hp = hp; v.t = t; v.a = a; v.o = o; v.mi = mi; v.sc = sc;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int           pre_s, pre_e, cnt;
    bit           found;
    logic [N-1:0] mask, hp;

    // table: no mole is lit before the first tick, so every press is a miss
    tbl[0] = mk(1, 0, 5'h1f,  0, 0, 0, 0, 0);  // idle ignores tick and hits
    tbl[1] = mk(1, 1, 5'h01, GS, 1, 0, 0, 0);  // only start acts
    tbl[2] = mk(0, 0, 5'h03, GS, 1, 0, 2, 0);  // penalty floors score at 0
    tbl[3] = mk(0, 0, 5'h04, GS, 1, 0, 3, 0);
    tbl[4] = mk(0, 1, 5'h00, GS, 1, 0, 3, 0);  // start while playing ignored
    tbl[5] = mk(0, 0, 5'h1f, GS, 1, 0, SMAX, 0);  // 3+5 saturates
    for (int i = 0; i < GS; i++)
      tbl[6 + i] = mk(1, 0, 5'h00, GS - 1 - i, (i != GS - 1), (i == GS - 1), SMAX, 0);
    tbl[18] = mk(0, 1, 5'h1f, GS, 1, 0, 0, 0);  // restart from over

    // clock / reset
    reset = 1'b0; tick = 1'b0; start = 1'b0; hit_pulse = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].tk, tbl[i].st, tbl[i].hp);
      chk($sformatf("tbl%0d time_left", i), int'(time_left), tbl[i].t);
      chk($sformatf("tbl%0d game_active", i), int'(game_active), tbl[i].a);
      chk($sformatf("tbl%0d game_over", i), int'(game_over), tbl[i].o);
      chk($sformatf("tbl%0d misses", i), int'(misses), tbl[i].mi);
      chk($sformatf("tbl%0d score", i), int'(score), tbl[i].sc);
      if (tbl[i].o) chk($sformatf("tbl%0d led at over", i), int'(mole_led), 0);
    end

    // two lit moles hit in the same cycle
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_state != 1) cycle(0, 1, '0);
      else if ($countones(m_led()) == 2) found = 1;
      else cycle(1, 0, '0);
    end
    chk("two lit moles reached", int'(found), 1);
    if (found) begin
      pre_s = m_score;
      cycle(0, 0, m_led());
      chk("double hit score", int'(score), imin(pre_s + 2, SMAX));
      chk("double hit leds off", int'(mole_led), 0);
    end

    // hit on the tick where the mole would expire
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_state != 1) cycle(0, 1, '0);
      else if (m_ones_mask() != '0 && m_time != 1) found = 1;
      else cycle(1, 0, '0);
    end
    chk("expiring mole reached", int'(found), 1);
    if (found) begin
      mask  = m_ones_mask();
      cnt   = $countones(mask);
      pre_s = m_score;
      pre_e = m_esc;
      cycle(1, 0, mask);
      chk("expire-hit score", int'(score), imin(pre_s + cnt, SMAX));
      chk("expire-hit escaped", int'(escaped), pre_e);
      chk("expire-hit led off", int'(mole_led & mask), 0);
    end

    // score saturation: hit every lit mole until the counter is full, then hit again
    found = 0;
    for (int k = 0; k < 120 && !found; k++) begin
      if (m_state != 1) cycle(0, 1, '0);
      else if (m_score == SMAX && m_led() != '0) found = 1;
      else if (m_led() != '0) cycle(0, 0, m_led());
      else cycle(1, 0, '0);
    end
    chk("score full reached", int'(found), 1);
    if (found) begin
      cycle(0, 0, m_led());
      chk("score saturated", int'(score), SMAX);
    end

    // asynchronous reset mid-game, sampled before any clock edge
    chk("pre-reset playing", int'(game_active), 1);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async");
    model_reset();
    @(negedge clk);
    chk_reset_outputs("held");
    reset = 1'b1;

    // random play
    for (int k = 0; k < 1500; k++) begin
      case ($urandom_range(0, 3))
        0:       hp = m_led();
        1:       hp = N'($urandom);
        default: hp = '0;
      endcase
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, hp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
